jt12_fir_seq: RTL and testbench

Sequencer for a RAM-based symmetric stereo FIR, sitting between the FM/PSG sample strobe and a shared single-multiplier MAC datapath. On each rising edge of `sample` it writes one new input word per channel into a circular tap buffer. It then walks each channel's half-filter, issuing paired symmetric tap addresses, coefficient addresses and MAC control strobes. It also handles pending/overrun samples and a full history clear.

---
 rtl/jt12_fir_seq_if.sv | 35 +++
 rtl/jt12_fir_seq.sv | 148 ++++++++++++++
 tb/tb_jt12_fir_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt12_fir_seq_if.sv
// Control bus between the symmetric-FIR sequencer (master) and its tap RAM / MAC datapath (slave).
interface jt12_fir_seq_if #(
  parameter int AW = 7,
  parameter int CW = 6
);
  logic          sample;
  logic          clr;
  logic          busy;
  logic          wr_en;
  logic          wr_zero;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [CW-1:0] coeff_addr;
  logic [1:0]    rd_ch;
  logic          mac_en;
  logic          mac_first;
  logic          mac_mid;
  logic          mac_last;
  logic [1:0]    mac_ch;
  logic          done;
  logic          overrun;

  modport master (
    input  sample, clr,
    output busy, wr_en, wr_zero, wr_addr, rd_addr_a, rd_addr_b, coeff_addr, rd_ch,
           mac_en, mac_first, mac_mid, mac_last, mac_ch, done, overrun
  );

  modport slave (
    output sample, clr,
    input  busy, wr_en, wr_zero, wr_addr, rd_addr_a, rd_addr_b, coeff_addr, rd_ch,
           mac_en, mac_first, mac_mid, mac_last, mac_ch, done, overrun
  );
endinterface

// File: rtl/jt12_fir_seq.sv
// Sequencer for a RAM-based symmetric stereo FIR: writes one tap per sample edge, then walks each
// channel's half-filter with paired symmetric read addresses and one-cycle-delayed MAC strobes.
module jt12_fir_seq #(
  parameter int stages   = 73,
  parameter int channels = 2
) (
  input logic            clk,
  input logic            rst_n,
  jt12_fir_seq_if.master bus
);
  localparam int AW = $clog2(stages);
  localparam int CW = $clog2((stages + 1) / 2);
  localparam int H  = (stages - 1) / 2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(stages - 1);
  localparam logic [AW-1:0] STAGES_W  = AW'(stages);
  localparam logic [CW-1:0] K_MID     = CW'(H);
  localparam logic [1:0]    LAST_CH   = 2'(channels - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, WRITE, RUN, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] nw;
  logic [AW-1:0] clr_addr;
  logic [CW-1:0] k;
  logic [1:0]    ch;
  logic          pend_s, pend_c, last_sample;
  logic          mac_en_q, mac_first_q, mac_mid_q, mac_last_q;
  logic [1:0]    mac_ch_q;
  logic          done_q, overrun_q;

  logic          sample_edge, want_s, want_c, k_mid, start_write, start_clear;
  logic [AW-1:0] wr_next, k_w, rem, addr_a, addr_b;

  assign sample_edge = bus.sample & ~last_sample;
  assign want_s      = pend_s | sample_edge;
  assign want_c      = pend_c | bus.clr;
  assign k_mid       = (k == K_MID);
  assign k_w         = AW'(k);
  assign wr_next     = (nw == LAST_ADDR) ? '0 : nw + AW'(1);

  // Modular addressing without a divider. Every true result lies in [0, stages), and stages is
  // odd so it is below 2**AW; wrapping AW-bit arithmetic therefore lands on the exact value.
  // nw+1+k reaches stages exactly when k >= stages-1-nw, which avoids forming the wide sum.
  assign rem = LAST_ADDR - nw;

  always_comb begin
    addr_a = (nw >= k_w) ? nw - k_w : nw + STAGES_W - k_w;
    addr_b = (k_w >= rem) ? k_w - rem : nw + AW'(1) + k_w;
  end

  always_comb begin
    // NOTE: state_nxt takes its default before the case so every path assigns it; no latch.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (want_s)      state_nxt = WRITE;
        else if (want_c) state_nxt = CLEAR;
      end
      CLEAR: if (clr_addr == LAST_ADDR) state_nxt = IDLE;
      WRITE: state_nxt = RUN;
      RUN:   if (k_mid && (ch == LAST_CH)) state_nxt = FLUSH;
      FLUSH: begin
        if (want_s)      state_nxt = WRITE;
        else if (want_c) state_nxt = CLEAR;
        else             state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign start_write = (state_nxt == WRITE);
  assign start_clear = (state_nxt == CLEAR) && (state != CLEAR);

  // Address-phase outputs are decoded from registered state, so reset forces them low at once.
  assign bus.busy       = (state != IDLE);
  assign bus.wr_en      = (state == WRITE) || (state == CLEAR);
  assign bus.wr_zero    = (state == CLEAR);
  assign bus.wr_addr    = (state == WRITE) ? wr_next : ((state == CLEAR) ? clr_addr : '0);
  assign bus.rd_addr_a  = (state == RUN) ? addr_a : '0;
  assign bus.rd_addr_b  = (state == RUN) ? addr_b : '0;
  assign bus.coeff_addr = (state == RUN) ? k : '0;
  assign bus.rd_ch      = (state == RUN) ? ch : '0;
  assign bus.mac_en     = mac_en_q;
  assign bus.mac_first  = mac_first_q;
  assign bus.mac_mid    = mac_mid_q;
  assign bus.mac_last   = mac_last_q;
  assign bus.mac_ch     = mac_ch_q;
  assign bus.done       = done_q;
  assign bus.overrun    = overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      nw          <= LAST_ADDR;
      clr_addr    <= '0;
      k           <= '0;
      ch          <= '0;
      pend_s      <= 1'b0;
      pend_c      <= 1'b0;
      last_sample <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      mac_mid_q   <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_ch_q    <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      state       <= state_nxt;
      last_sample <= bus.sample;

      if (state == WRITE)
        nw <= wr_next;
      else if ((state == CLEAR) && (clr_addr == LAST_ADDR))
        nw <= LAST_ADDR;

      if ((state == RUN) && !k_mid) k <= k + CW'(1);
      else                          k <= '0;

      if (state != RUN) ch <= '0;
      else if (k_mid)   ch <= ch + 2'd1;

      clr_addr <= ((state == CLEAR) && (clr_addr != LAST_ADDR)) ? clr_addr + AW'(1) : '0;

      // A second edge while one is already queued is dropped and flagged.
      if (start_write)
        pend_s <= 1'b0;
      else if (sample_edge && (state != IDLE))
        pend_s <= 1'b1;
      overrun_q <= sample_edge && pend_s && (state != IDLE);

      if (start_clear)
        pend_c <= 1'b0;
      else if (bus.clr && (state != IDLE) && (state != CLEAR))
        pend_c <= 1'b1;

      // RAM read data arrives one cycle after the address, so the MAC flags trail by one.
      mac_en_q    <= (state == RUN);
      mac_first_q <= (state == RUN) && (k == '0);
      mac_mid_q   <= (state == RUN) && k_mid;
      mac_last_q  <= (state == RUN) && k_mid;
      mac_ch_q    <= (state == RUN) ? ch : '0;
      done_q      <= mac_last_q && (mac_ch_q == LAST_CH);
    end
  end
endmodule

// File: tb/tb_jt12_fir_seq.sv
// Scoreboard bench for jt12_fir_seq: a default 73-tap stereo instance and a 3-tap mono instance.
module tb_jt12_fir_seq;
  localparam int N = 73;
  localparam int H = 36;

  typedef struct {
    int cyc;
    int a;
    int b;
    int ch;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc      = 0;
  int   errors   = 0;
  int   checks   = 0;
  int   max_addr = 0;
  int   s_max    = 0;
  int   w_next   = 0;
  int   c0       = 0;

  ev_t q_wr[$], q_first[$], q_last[$], q_done[$], q_ovr[$];
  ev_t s_wr[$], s_first[$], s_last[$], s_done[$];

  jt12_fir_seq_if #(.AW(7), .CW(6)) bus ();
  jt12_fir_seq_if #(.AW(2), .CW(1)) bus_s ();

  jt12_fir_seq #(.stages(73), .channels(2)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  jt12_fir_seq #(.stages(3),  .channels(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns just after the posedge that starts cycle n.
  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int big_outs_or();
    return int'(bus.busy | bus.wr_en | bus.wr_zero | (|bus.wr_addr) | (|bus.rd_addr_a) |
                (|bus.rd_addr_b) | (|bus.coeff_addr) | (|bus.rd_ch) | bus.mac_en |
                bus.mac_first | bus.mac_mid | bus.mac_last | (|bus.mac_ch) | bus.done |
                bus.overrun);
  endfunction

  task automatic push_frame(input int f0, input int w);
    q_wr.push_back('{f0 + 1, w, 0, 0});
    for (int c = 0; c < 2; c++) begin
      q_first.push_back('{f0 + 3 + c * (H + 1), w, (w + 1) % N, c});
      q_last.push_back('{f0 + 3 + H + c * (H + 1), (w + N - H) % N, (w + H + 1) % N, c});
    end
    q_done.push_back('{f0 + 77, 0, 0, 0});
  endtask

  task automatic start_frame(output int f0);
    f0 = cyc;
    push_frame(f0, w_next);
    w_next = (w_next + 1) % N;
    bus.sample = 1'b1;
    at_cycle(f0 + 1);
    bus.sample = 1'b0;
  endtask

  task automatic pulse_sample(input int at);
    at_cycle(at);
    bus.sample = 1'b1;
    at_cycle(at + 1);
    bus.sample = 1'b0;
  endtask

  // Monitor for the 73-tap instance.
  int pa = 0, pb = 0, pk = 0, pch = 0;
  always @(negedge clk) begin : mon_big
    ev_t e;
    if (rst_n) begin
      if (bus.wr_en) begin
        check("wr_expected", int'(q_wr.size() != 0), 1);
        if (q_wr.size() != 0) begin
          e = q_wr.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr", int'(bus.wr_addr), e.a);
          check("wr_zero", int'(bus.wr_zero), e.b);
        end
      end
      if (bus.mac_first) begin
        check("first_expected", int'(q_first.size() != 0), 1);
        if (q_first.size() != 0) begin
          e = q_first.pop_front();
          check("first_cycle", cyc, e.cyc);
          check("first_rd_a", pa, e.a);
          check("first_rd_b", pb, e.b);
          check("first_coeff", pk, 0);
          check("first_rd_ch", pch, e.ch);
          check("first_mac_ch", int'(bus.mac_ch), e.ch);
          check("first_mac_en", int'(bus.mac_en), 1);
          check("first_mac_mid", int'(bus.mac_mid), 0);
        end
      end
      if (bus.mac_last) begin
        check("last_expected", int'(q_last.size() != 0), 1);
        if (q_last.size() != 0) begin
          e = q_last.pop_front();
          check("last_cycle", cyc, e.cyc);
          check("last_rd_a", pa, e.a);
          check("last_rd_b", pb, e.b);
          check("last_coeff", pk, H);
          check("last_mac_ch", int'(bus.mac_ch), e.ch);
          check("last_mac_mid", int'(bus.mac_mid), 1);
          check("last_mac_en", int'(bus.mac_en), 1);
        end
      end
      if (bus.done) begin
        check("done_expected", int'(q_done.size() != 0), 1);
        if (q_done.size() != 0) begin
          e = q_done.pop_front();
          check("done_cycle", cyc, e.cyc);
        end
      end
      if (bus.overrun) begin
        check("overrun_expected", int'(q_ovr.size() != 0), 1);
        if (q_ovr.size() != 0) begin
          e = q_ovr.pop_front();
          check("overrun_cycle", cyc, e.cyc);
        end
      end
      if (int'(bus.wr_addr)   > max_addr) max_addr = int'(bus.wr_addr);
      if (int'(bus.rd_addr_a) > max_addr) max_addr = int'(bus.rd_addr_a);
      if (int'(bus.rd_addr_b) > max_addr) max_addr = int'(bus.rd_addr_b);
      pa  = int'(bus.rd_addr_a);
      pb  = int'(bus.rd_addr_b);
      pk  = int'(bus.coeff_addr);
      pch = int'(bus.rd_ch);
    end
  end

  // Monitor for the 3-tap instance.
  int spa = 0, spb = 0, spk = 0;
  always @(negedge clk) begin : mon_small
    ev_t e;
    if (rst_n) begin
      if (bus_s.wr_en) begin
        check("s_wr_expected", int'(s_wr.size() != 0), 1);
        if (s_wr.size() != 0) begin
          e = s_wr.pop_front();
          check("s_wr_cycle", cyc, e.cyc);
          check("s_wr_addr", int'(bus_s.wr_addr), e.a);
        end
      end
      if (bus_s.mac_first) begin
        check("s_first_expected", int'(s_first.size() != 0), 1);
        if (s_first.size() != 0) begin
          e = s_first.pop_front();
          check("s_first_cycle", cyc, e.cyc);
          check("s_first_rd_a", spa, e.a);
          check("s_first_rd_b", spb, e.b);
          check("s_first_coeff", spk, 0);
        end
      end
      if (bus_s.mac_last) begin
        check("s_last_expected", int'(s_last.size() != 0), 1);
        if (s_last.size() != 0) begin
          e = s_last.pop_front();
          check("s_last_cycle", cyc, e.cyc);
          check("s_last_rd_a", spa, e.a);
          check("s_last_rd_b", spb, e.b);
          check("s_last_coeff", spk, 1);
          check("s_last_mid", int'(bus_s.mac_mid), 1);
        end
      end
      if (bus_s.done) begin
        check("s_done_expected", int'(s_done.size() != 0), 1);
        if (s_done.size() != 0) begin
          e = s_done.pop_front();
          check("s_done_cycle", cyc, e.cyc);
        end
      end
      if (int'(bus_s.rd_addr_a) > s_max) s_max = int'(bus_s.rd_addr_a);
      if (int'(bus_s.rd_addr_b) > s_max) s_max = int'(bus_s.rd_addr_b);
      spa = int'(bus_s.rd_addr_a);
      spb = int'(bus_s.rd_addr_b);
      spk = int'(bus_s.coeff_addr);
    end
  end

  initial begin
    bus.sample   = 1'b0;
    bus.clr      = 1'b0;
    bus_s.sample = 1'b0;
    bus_s.clr    = 1'b0;

    // Reset state.
    at_cycle(3);
    check("rst_outputs_zero", big_outs_or(), 0);
    rst_n = 1'b1;
    at_cycle(5);
    check("idle_busy", int'(bus.busy), 0);

    // Single frame from IDLE: write addr 0 at c1, done at c77, busy through FLUSH.
    start_frame(c0);
    check("busy_c1", int'(bus.busy), 1);
    at_cycle(c0 + 38);
    check("mid_coeff", int'(bus.coeff_addr), H);
    check("mid_rd_a", int'(bus.rd_addr_a), 37);
    check("mid_rd_b", int'(bus.rd_addr_b), 37);
    at_cycle(c0 + 76);
    check("busy_flush", int'(bus.busy), 1);
    at_cycle(c0 + 77);
    check("busy_after_flush", int'(bus.busy), 0);

    // 79 more frames: write pointer wraps 72 -> 0.
    for (int i = 0; i < 79; i++) begin
      at_cycle(c0 + 78);
      start_frame(c0);
    end
    at_cycle(c0 + 78);

    // Two extra edges during RUN: one pending frame, one overrun.
    start_frame(c0);
    pulse_sample(c0 + 10);
    pulse_sample(c0 + 20);
    push_frame(c0 + 76, w_next);
    w_next = (w_next + 1) % N;
    q_ovr.push_back('{c0 + 21, 0, 0, 0});
    at_cycle(c0 + 76 + 80);
    check("ovr_idle_after", int'(bus.busy), 0);

    // Clear request during RUN: frame completes, then 73 zero writes, then restart at 0.
    start_frame(c0);
    at_cycle(c0 + 20);
    bus.clr = 1'b1;
    at_cycle(c0 + 21);
    bus.clr = 1'b0;
    for (int i = 0; i < N; i++) q_wr.push_back('{c0 + 77 + i, i, 1, 0});
    w_next = 0;
    at_cycle(c0 + 100);
    check("clear_busy", int'(bus.busy), 1);
    at_cycle(c0 + 155);
    check("clear_done_idle", int'(bus.busy), 0);
    start_frame(c0);
    at_cycle(c0 + 78);

    // Reset at RUN k=10 aborts the frame without done.
    c0 = cyc;
    q_wr.push_back('{c0 + 1, w_next, 0, 0});
    q_first.push_back('{c0 + 3, w_next, (w_next + 1) % N, 0});
    bus.sample = 1'b1;
    at_cycle(c0 + 1);
    bus.sample = 1'b0;
    at_cycle(c0 + 12);
    check("abort_coeff_k10", int'(bus.coeff_addr), 10);
    rst_n = 1'b0;
    #1;
    check("abort_outputs_zero", big_outs_or(), 0);
    at_cycle(c0 + 15);
    rst_n = 1'b1;
    w_next = 0;
    at_cycle(c0 + 17);
    start_frame(c0);
    at_cycle(c0 + 80);

    // 3-tap mono instance.
    c0 = cyc;
    s_wr.push_back('{c0 + 1, 0, 0, 0});
    s_first.push_back('{c0 + 3, 0, 1, 0});
    s_last.push_back('{c0 + 4, 2, 2, 0});
    s_done.push_back('{c0 + 5, 0, 0, 0});
    bus_s.sample = 1'b1;
    at_cycle(c0 + 1);
    bus_s.sample = 1'b0;
    at_cycle(c0 + 10);

    check("q_wr_drained", q_wr.size(), 0);
    check("q_first_drained", q_first.size(), 0);
    check("q_last_drained", q_last.size(), 0);
    check("q_done_drained", q_done.size(), 0);
    check("q_ovr_drained", q_ovr.size(), 0);
    check("s_wr_drained", s_wr.size(), 0);
    check("s_first_drained", s_first.size(), 0);
    check("s_last_drained", s_last.size(), 0);
    check("s_done_drained", s_done.size(), 0);
    check("addr_in_range", int'(max_addr < N), 1);
    check("s_addr_in_range", int'(s_max < 3), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
